reg_bank_arbiter: RTL and testbench
===================================

// Module: reg_bank_arbiter
// PURPOSE
//  - Shares one bank of DEPTH x WIDTH-bit registers among NUM_REQ requesters via req/gnt handshake.
//  - Round-robin arbitration; one read or write per grant; all register contents exported for debug/datapath taps.
//  - Sits between sequencing logic (counters, shifters, FSMs) and the shared register storage.
// PARAMETERS
//  NUM_REQ  4  number of requesters (2..8)
//  WIDTH    4  register width in bits
//  AW       2  address width; DEPTH = 2**AW registers (localparam, no out-of-range addresses)
// PORTS
//  clk     in   1               system clock, rising edge
//  reset   in   1               asynchronous, active-low reset
//  req     in   NUM_REQ         request per requester; held until its gnt
//  we      in   NUM_REQ         1 = write, 0 = read; stable while req high
//  addr    in   NUM_REQ*AW      requester i at [i*AW +: AW]; stable while req high
//  wdata   in   NUM_REQ*WIDTH   requester i at [i*WIDTH +: WIDTH]; stable while req high
//  gnt     out  NUM_REQ         one-hot, 1-cycle pulse: access of requester i completed
//  rdata   out  WIDTH           read data; valid in gnt cycle of a read; holds value otherwise
//  busy    out  1               1 while state = XFER
//  reg_q   out  DEPTH*WIDTH     all register contents, reg k at [k*WIDTH +: WIDTH]
// BEHAVIOUR
//  - Reset (reset=0, async): all registers 0, gnt 0, rdata 0, busy 0, ptr 0, owner 0, state ARB.
//  - FSM: ARB -> XFER when any eligible req; XFER -> ARB always (one cycle). Two cycles per access.
//  - ARB, cycle N: eligible = req & ~gnt (requester being granted this cycle is ignored).
//    Winner = first eligible index scanning ptr, ptr+1, ... mod NUM_REQ; latched into owner at edge.
//  - XFER, cycle N+1: at closing edge, if we[owner] reg[addr[owner]] <= wdata[owner];
//    else rdata <= reg[addr[owner]]; gnt[owner] <= 1; ptr <= (owner+1) mod NUM_REQ.
//  - Cycle N+2: gnt pulse visible; read data on rdata; write visible on reg_q. Latency req->gnt = 2 cycles.
//  - gnt cleared after one cycle; never more than one bit set.
//  - Back-to-back: ARB in the gnt cycle may start the next arbitration (one access per 2 cycles).
//  - req dropped before gnt: treated as abandoned only if dropped while in ARB; once owner latched,
//    access completes using inputs sampled in XFER.
//  - Read and write to same register by different requesters are serialized; later grant sees earlier write.
//  - Reset mid-XFER: access aborted, no write, no gnt, registers cleared.
//  - No req: stays in ARB, outputs hold (rdata keeps last read value).
// CONFIGURATION
//  - Macro REG_ARB_LOCK_EN: adds input port lock [NUM_REQ] after wdata.
//    Defined: if lock[owner]=1 at XFER edge, ptr not advanced and next ARB considers only owner's req
//    (others wait) until owner completes an access with lock=0.
//    Undefined: no lock port; pure round-robin as above.
// STRUCTURE
//  - Shared package reg_arb_pkg: state encodings ST_ARB=1'b0, ST_XFER=1'b1; ptr width function clog2.
//  - Sub-module rr_pick: combinational rotating-priority picker (req, ptr -> one-hot + index, valid).
//  - Storage, FSM, owner/ptr registers and lock logic live in the top module.
// TESTING
//  1 Reset: drive reset=0 mid-run -> reg_q=0, gnt=0, rdata=0, busy=0 immediately (async).
//  2 Single write/read: req0 we=1 addr=2 wdata=4'hA -> gnt=4'b0001 2 cycles later, reg_q[11:8]=A;
//    then req0 we=0 addr=2 -> gnt pulse with rdata=4'hA.
//  3 Round-robin: req=4'b1111 held, re-asserted after each gnt -> grant order 0,1,2,3,0, one per 2 cycles.
//  4 Conflict: req1 write addr=1 4'h5 and req2 read addr=1 same cycle, ptr=0 -> req1 granted first,
//    req2 gnt 2 cycles later with rdata=4'h5.
//  5 Reset in XFER: req3 write addr=3 4'hF, assert reset during busy=1 -> no gnt, reg_q[15:12]=0.
//  6 LOCK_EN build: req0 lock=1 with req1 pending -> 3 consecutive gnt0; lock=0 on 3rd -> gnt1 next.

Source files
------------

// File: rtl/reg_arb_pkg.sv
// Shared definitions for the register-bank arbiter: FSM state encoding and
// a constant-evaluable ceil(log2) used to size the round-robin pointer.
package reg_arb_pkg;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/reg_bank_arbiter_rr_pick.sv
// Combinational rotating-priority picker: scans requests starting at the
// pointer position and returns the first one found as one-hot and index.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PW      = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PW-1:0]      i_ptr,
    output logic [NUM_REQ-1:0] o_onehot,
    output logic [PW-1:0]      o_idx,
    output logic               o_valid
);

    int w_pos;

    // First asserted request at or after the pointer, wrapping modulo NUM_REQ
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        w_pos    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_pos = (int'(i_ptr) + k) % NUM_REQ;
            if (!o_valid && i_req[w_pos]) begin
                o_valid         = 1'b1;
                o_onehot[w_pos] = 1'b1;
                o_idx           = PW'(w_pos);
            end
        end
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Register bank shared by NUM_REQ requesters through a round-robin
// req/gnt handshake. Each access takes two cycles: ARB picks an owner,
// XFER performs the read or write and pulses the owner's grant.
// Optional feature: define REG_ARB_LOCK_EN to add the i_lock port, which
// lets the current owner keep the bank across consecutive accesses.
module reg_bank_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4,
    parameter int AW      = 2
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [NUM_REQ-1:0]         i_we,
    input  logic [NUM_REQ*AW-1:0]      i_addr,
    input  logic [NUM_REQ*WIDTH-1:0]   i_wdata,
`ifdef REG_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]         i_lock,
`endif
    output logic [NUM_REQ-1:0]         o_gnt,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_busy,
    output logic [(2**AW)*WIDTH-1:0]   o_reg_q
);

    localparam int DEPTH = 2 ** AW;
    localparam int PW    = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ);

    state_t             r_state;
    logic [PW-1:0]      r_ptr;
    logic [PW-1:0]      r_owner;
    logic [NUM_REQ-1:0] r_own_oh;
    logic [NUM_REQ-1:0] r_gnt;
    logic [WIDTH-1:0]   r_rdata;
    logic [WIDTH-1:0]   r_regs [DEPTH];
    logic               r_locked;

    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_pick_oh;
    logic [PW-1:0]      w_pick_idx;
    logic               w_pick_vld;
    logic               w_own_we;
    logic [AW-1:0]      w_own_addr;
    logic [WIDTH-1:0]   w_own_wdata;
    logic               w_own_lock;
    logic [PW-1:0]      w_ptr_nxt;

    // Eligible requests: drop the one being granted this cycle, and while
    // locked only the owner may compete
    always_comb begin
        w_elig = i_req & ~r_gnt;
        if (r_locked) w_elig = w_elig & r_own_oh;
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_pick (
        .i_req    (w_elig),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_oh),
        .o_idx    (w_pick_idx),
        .o_valid  (w_pick_vld)
    );

    // Owner's request fields, sampled live during XFER
    always_comb begin
        w_own_we    = i_we[r_owner];
        w_own_addr  = i_addr[int'(r_owner)*AW +: AW];
        w_own_wdata = i_wdata[int'(r_owner)*WIDTH +: WIDTH];
`ifdef REG_ARB_LOCK_EN
        w_own_lock  = i_lock[r_owner];
`else
        w_own_lock  = 1'b0;
`endif
        w_ptr_nxt   = (r_owner == PW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
    end

    // Arbitration FSM, storage update, grant pulse and pointer rotation
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state  <= ST_ARB;
            r_ptr    <= '0;
            r_owner  <= '0;
            r_own_oh <= '0;
            r_gnt    <= '0;
            r_rdata  <= '0;
            r_locked <= 1'b0;
            for (int k = 0; k < DEPTH; k++) r_regs[k] <= '0;
        end else begin
            case (r_state)
                ST_ARB: begin
                    r_gnt <= '0;
                    if (w_pick_vld) begin
                        r_owner  <= w_pick_idx;
                        r_own_oh <= w_pick_oh;
                        r_state  <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (w_own_we) r_regs[w_own_addr] <= w_own_wdata;
                    else          r_rdata <= r_regs[w_own_addr];
                    r_gnt <= r_own_oh;
                    // A locking owner keeps priority; otherwise rotate past it
                    if (w_own_lock) begin
                        r_locked <= 1'b1;
                    end else begin
                        r_locked <= 1'b0;
                        r_ptr    <= w_ptr_nxt;
                    end
                    r_state <= ST_ARB;
                end
            endcase
        end
    end

    assign o_gnt   = r_gnt;
    assign o_rdata = r_rdata;
    assign o_busy  = (r_state == ST_XFER);

    for (genvar g = 0; g < DEPTH; g++) begin : g_regq
        assign o_reg_q[g*WIDTH +: WIDTH] = r_regs[g];
    end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Scoreboard bench for reg_bank_arbiter (NUM_REQ=4, WIDTH=4, AW=2).
// Expected grants come from a request-set model: every request in a batch
// is served in round-robin order from the model pointer, one per 2 cycles.
module tb_reg_bank_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req, we;
    logic [7:0]  addr;
    logic [15:0] wdata;
`ifdef REG_ARB_LOCK_EN
    logic [3:0]  lock;
`endif
    logic [3:0]  gnt;
    logic [3:0]  rdata;
    logic        busy;
    logic [15:0] regq;

    reg_bank_arbiter #(.NUM_REQ(4), .WIDTH(4), .AW(2)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .i_req   (req),
        .i_we    (we),
        .i_addr  (addr),
        .i_wdata (wdata),
`ifdef REG_ARB_LOCK_EN
        .i_lock  (lock),
`endif
        .o_gnt   (gnt),
        .o_rdata (rdata),
        .o_busy  (busy),
        .o_reg_q (regq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int ntests = 0;
    int nfail  = 0;

    task automatic check(input string nm, input int act, input int exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model state
    typedef struct {
        int          idx;
        int          cyc;     // negative: do not check timing
        logic [3:0]  rdata;
        logic [15:0] regq;
    } exp_t;

    exp_t       sbq[$];
    logic [3:0] mem [4];
    logic [3:0] m_last_rd;
    int         m_ptr;

    function automatic logic [15:0] m_regq();
        return {mem[3], mem[2], mem[1], mem[0]};
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 4; i++) mem[i] = 4'h0;
        m_last_rd = 4'h0;
        m_ptr     = 0;
    endtask

    task automatic m_access(input int j, input logic w, input logic [1:0] a,
                            input logic [3:0] d, input int c);
        exp_t e;
        if (w) mem[a] = d;
        else   m_last_rd = mem[a];
        e.idx = j; e.cyc = c; e.rdata = m_last_rd; e.regq = m_regq();
        sbq.push_back(e);
    endtask

    // Monitor: every grant pulse pops one expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && gnt !== 4'b0000) begin
            if (sbq.size() == 0) begin
                check("unexpected_gnt", int'(gnt), 0);
            end else begin
                e = sbq.pop_front();
                check("gnt", int'(gnt), 1 << e.idx);
                if (e.cyc >= 0) check("gnt_cycle", cyc, e.cyc);
                check("rdata", int'(rdata), int'(e.rdata));
                check("reg_q", int'(regq), int'(e.regq));
            end
        end
    end

    // Issue a set of simultaneous requests (called at a negedge), hold each
    // until granted, then confirm idle behaviour
    task automatic run_batch(input logic [3:0] set, input logic [3:0] w,
                             input logic [7:0] a, input logic [15:0] d);
        int c, k, last;
        logic [3:0] pending;
        c = cyc; k = 0; last = m_ptr;
        for (int n = 0; n < 4; n++) begin
            int j;
            j = (m_ptr + n) % 4;
            if (set[j]) begin
                m_access(j, w[j], a[j*2 +: 2], d[j*4 +: 4], c + 2 + 2*k);
                k++;
                last = j;
            end
        end
        m_ptr = (last + 1) % 4;
        req = set; we = w; addr = a; wdata = d;
        pending = set;
        for (int t = 0; t < 40 && pending != 4'b0; t++) begin
            @(negedge clk);
            pending = pending & ~gnt;
            req = pending;
        end
        if (pending != 4'b0) begin
            check("batch_timeout", int'(pending), 0);
            req = 4'b0;
            sbq.delete();
        end
        repeat (2) @(negedge clk);
        check("idle_busy", int'(busy), 0);
        check("idle_rdata_hold", int'(rdata), int'(m_last_rd));
        check("idle_sb_empty", sbq.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
`ifdef REG_ARB_LOCK_EN
        lock = '0;
`endif
        m_reset();
        repeat (2) @(negedge clk);
        check("rst_reg_q", int'(regq), 0);
        check("rst_gnt", int'(gnt), 0);
        check("rst_rdata", int'(rdata), 0);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single write then read of register 2 by requester 0
        run_batch(4'b0001, 4'b0001, 8'h02, 16'h000A);
        run_batch(4'b0001, 4'b0000, 8'h02, 16'h0000);

        // Asynchronous reset while idle with non-zero state
        rst_n = 1'b0;
        #1;
        check("async_rst_reg_q", int'(regq), 0);
        check("async_rst_gnt", int'(gnt), 0);
        check("async_rst_rdata", int'(rdata), 0);
        check("async_rst_busy", int'(busy), 0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Write/read conflict on register 1, pointer at 0
        run_batch(4'b0110, 4'b0010, 8'h14, 16'h0050);

        // All requesters held high: five grants in rotating order
        begin
            int c, last;
            c = cyc;
            last = m_ptr;
            for (int k = 0; k < 5; k++) begin
                last = (m_ptr + k) % 4;
                m_access(last, 1'b0, 2'd1, 4'h0, c + 2 + 2*k);
            end
            m_ptr = (last + 1) % 4;
            req = 4'b1111; we = 4'b0000; addr = 8'h55; wdata = 16'h0;
            for (int t = 0; t < 30 && sbq.size() != 0; t++) begin
                @(negedge clk);
                #1;
            end
            req = 4'b0000;
            check("rr_sb_empty", sbq.size(), 0);
            sbq.delete();
            @(negedge clk);
        end

        // Randomized request sets
        for (int b = 0; b < 40; b++) begin
            run_batch(4'($urandom_range(1, 15)), 4'($urandom), 8'($urandom), 16'($urandom));
        end

        // Reset asserted while the write is in XFER
        req = 4'b1000; we = 4'b1000; addr = 8'hC0; wdata = 16'hF000;
        @(posedge clk);
        #1;
        check("xfer_busy", int'(busy), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("xfer_rst_busy", int'(busy), 0);
        check("xfer_rst_gnt", int'(gnt), 0);
        check("xfer_rst_reg_q", int'(regq), 0);
        req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        repeat (3) @(negedge clk);
        check("xfer_rst_after_reg_q", int'(regq), 0);
        check("xfer_rst_sb_empty", sbq.size(), 0);

`ifdef REG_ARB_LOCK_EN
        // Requester 0 locks the bank for three accesses, then requester 1
        begin
            int n0;
            logic seen1;
            n0 = 0; seen1 = 1'b0;
            for (int k = 0; k < 3; k++) m_access(0, 1'b0, 2'd0, 4'h0, -1);
            m_access(1, 1'b0, 2'd0, 4'h0, -1);
            m_ptr = 2;
            lock = 4'b0001; req = 4'b0011; we = 4'b0000; addr = 8'h00;
            for (int t = 0; t < 40 && !seen1; t++) begin
                @(negedge clk);
                if (gnt[0]) begin
                    n0++;
                    if (n0 == 2) lock = 4'b0000;
                    if (n0 == 3) req[0] = 1'b0;
                end
                if (gnt[1]) begin
                    check("lock_gnt0_count", n0, 3);
                    req[1] = 1'b0;
                    seen1 = 1'b1;
                end
            end
            req = 4'b0000;
            check("lock_done", int'(seen1), 1);
            repeat (2) @(negedge clk);
            check("lock_sb_empty", sbq.size(), 0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
